// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser plus independent per-bit debounce for the
// slide switches that feed the 8-bit magnitude comparator. Produces clean
// operands (SW_DB), a one-cycle change strobe and a settled flag.
module sw_debounce #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic             CLK100MHZ,
    input  logic             BTNC,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] SW_DB,
    output logic             CHANGED,
    output logic             STABLE
);

    // Terminal count: a differing level seen on this many edges is accepted.
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_db;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic             r_changed;
    logic             r_stable;

    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0] w_db_nxt;
    logic [WIDTH-1:0] w_accept;

    // Next-state for each bit: clear on agreement, count on difference,
    // accept the synchronised level once the count reaches terminal.
    always_comb begin
        w_db_nxt = r_db;
        w_accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = '0;
            if (r_s2[i] != r_db[i]) begin
                // >= rather than == so a corrupted counter still cannot wrap
                if (r_cnt[i] >= CNT_TERM) begin
                    w_db_nxt[i] = r_s2[i];
                    w_accept[i] = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Synchroniser, counters and registered outputs; reset discards any
    // pending change and takes priority over every update.
    always_ff @(posedge CLK100MHZ) begin
        if (BTNC) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_db      <= '0;
            r_changed <= 1'b0;
            r_stable  <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1      <= SW;
            r_s2      <= r_s1;
            r_db      <= w_db_nxt;
            r_changed <= |w_accept;
            r_stable  <= (r_s2 == r_db);
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign SW_DB   = r_db;
    assign CHANGED = r_changed;
    assign STABLE  = r_stable;

endmodule

// File: tb/tb_sw_debounce.sv
// Testbench for sw_debounce with DEBOUNCE_CYCLES = 4: directed vector table,
// hand-written corner sequences, and randomized stimulus against a
// history-window reference model.
module tb_sw_debounce;

    localparam int W  = 16;
    localparam int DC = 4;
    localparam int CW = 3;

    logic          CLK100MHZ = 1'b0;
    logic          BTNC;
    logic [W-1:0]  SW;
    logic [W-1:0]  SW_DB;
    logic          CHANGED;
    logic          STABLE;

    int n_chk  = 0;
    int n_pass = 0;

    sw_debounce #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W(CW)
    ) dut (
        .CLK100MHZ(CLK100MHZ),
        .BTNC(BTNC),
        .SW(SW),
        .SW_DB(SW_DB),
        .CHANGED(CHANGED),
        .STABLE(STABLE)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    // Reference model: keeps the raw samples taken since reset. The level the
    // debouncer sees at an edge is the raw sample from two edges earlier (0 if
    // none since reset). A bit is accepted when that delayed level differed
    // from the accepted value on each of the last DC edges.
    logic [W-1:0] raw_q[$];
    logic [W-1:0] m_db  = '0;
    logic         m_chg = 1'b0;
    logic         m_stb = 1'b0;

    function automatic logic [W-1:0] s2_ago(int j);
        int idx;
        idx = raw_q.size() - 2 - j;
        if (idx >= 0) return raw_q[idx];
        return '0;
    endfunction

    always @(posedge CLK100MHZ) begin
        logic [W-1:0] nxt;
        logic [W-1:0] past;
        logic         acc;
        logic         all_diff;
        if (BTNC) begin
            raw_q.delete();
            m_db  = '0;
            m_chg = 1'b0;
            m_stb = 1'b0;
        end else begin
            m_stb = (s2_ago(0) == m_db);
            nxt   = m_db;
            acc   = 1'b0;
            for (int i = 0; i < W; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DC; j++) begin
                    past = s2_ago(j);
                    if (past[i] == m_db[i]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    nxt[i] = ~m_db[i];
                    acc    = 1'b1;
                end
            end
            m_db  = nxt;
            m_chg = acc;
            raw_q.push_back(SW);
            if (raw_q.size() > DC + 4) void'(raw_q.pop_front());
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // One clock edge, then compare all outputs against the model.
    task automatic cyc();
        @(posedge CLK100MHZ);
        #1;
        chk("model_db",  SW_DB, m_db);
        chk("model_chg", {15'b0, CHANGED}, {15'b0, m_chg});
        chk("model_stb", {15'b0, STABLE},  {15'b0, m_stb});
    endtask

    typedef struct {
        logic [W-1:0] sw;
        logic         btnc;
        logic [W-1:0] db;
        logic         chg;
        logic         stb;
    } vec_t;

    function automatic vec_t mk(logic [W-1:0] sw, logic btnc, logic [W-1:0] db, logic chg, logic stb);
        vec_t v;
        v.sw = sw; v.btnc = btnc; v.db = db; v.chg = chg; v.stb = stb;
        return v;
    endfunction

    vec_t tbl[25];

    initial begin
        int  k;
        bit  dip;
        int  r;

        // reset with SW high, release, settle, return to 0, then clean 00A5 step
        k = 0;
        tbl[k++] = mk(16'hFFFF, 1, 16'h0000, 0, 0);
        tbl[k++] = mk(16'hFFFF, 1, 16'h0000, 0, 0);
        tbl[k++] = mk(16'hFFFF, 0, 16'h0000, 0, 1);
        tbl[k++] = mk(16'hFFFF, 0, 16'h0000, 0, 1);
        tbl[k++] = mk(16'hFFFF, 0, 16'h0000, 0, 0);
        tbl[k++] = mk(16'hFFFF, 0, 16'h0000, 0, 0);
        tbl[k++] = mk(16'hFFFF, 0, 16'h0000, 0, 0);
        tbl[k++] = mk(16'hFFFF, 0, 16'hFFFF, 1, 0);
        tbl[k++] = mk(16'hFFFF, 0, 16'hFFFF, 0, 1);
        tbl[k++] = mk(16'hFFFF, 0, 16'hFFFF, 0, 1);
        tbl[k++] = mk(16'h0000, 0, 16'hFFFF, 0, 1);
        tbl[k++] = mk(16'h0000, 0, 16'hFFFF, 0, 1);
        tbl[k++] = mk(16'h0000, 0, 16'hFFFF, 0, 0);
        tbl[k++] = mk(16'h0000, 0, 16'hFFFF, 0, 0);
        tbl[k++] = mk(16'h0000, 0, 16'hFFFF, 0, 0);
        tbl[k++] = mk(16'h0000, 0, 16'h0000, 1, 0);
        tbl[k++] = mk(16'h0000, 0, 16'h0000, 0, 1);
        tbl[k++] = mk(16'h00A5, 0, 16'h0000, 0, 1);
        tbl[k++] = mk(16'h00A5, 0, 16'h0000, 0, 1);
        tbl[k++] = mk(16'h00A5, 0, 16'h0000, 0, 0);
        tbl[k++] = mk(16'h00A5, 0, 16'h0000, 0, 0);
        tbl[k++] = mk(16'h00A5, 0, 16'h0000, 0, 0);
        tbl[k++] = mk(16'h00A5, 0, 16'h00A5, 1, 0);
        tbl[k++] = mk(16'h00A5, 0, 16'h00A5, 0, 1);
        tbl[k++] = mk(16'h00A5, 0, 16'h00A5, 0, 1);

        BTNC = 1'b1;
        SW   = 16'hFFFF;
        for (int i = 0; i < 25; i++) begin
            SW   = tbl[i].sw;
            BTNC = tbl[i].btnc;
            cyc();
            chk($sformatf("vec%0d_db", i),  SW_DB, tbl[i].db);
            chk($sformatf("vec%0d_chg", i), {15'b0, CHANGED}, {15'b0, tbl[i].chg});
            chk($sformatf("vec%0d_stb", i), {15'b0, STABLE},  {15'b0, tbl[i].stb});
        end

        // back to all-zero and settle
        SW = 16'h0000;
        for (int i = 0; i < 8; i++) cyc();

        // glitch on SW[0] three cycles long: never accepted, STABLE dips
        dip = 1'b0;
        SW  = 16'h0001;
        for (int e = 1; e <= 11; e++) begin
            if (e == 4) SW = 16'h0000;
            cyc();
            chk("glitch_db",  SW_DB, 16'h0000);
            chk("glitch_chg", {15'b0, CHANGED}, 16'h0000);
            if (!STABLE) dip = 1'b1;
        end
        chk("glitch_stb_dip", {15'b0, dip}, 16'h0001);
        chk("glitch_stb_end", {15'b0, STABLE}, 16'h0001);

        // bounce SW[8] every 2 cycles for 20 cycles, then hold high
        for (int c = 0; c < 20; c++) begin
            SW = ((c / 2) % 2 == 0) ? 16'h0100 : 16'h0000;
            cyc();
            chk("bounce_hold_db",  SW_DB, 16'h0000);
            chk("bounce_hold_chg", {15'b0, CHANGED}, 16'h0000);
        end
        SW = 16'h0100;
        for (int e = 1; e <= 8; e++) begin
            cyc();
            chk($sformatf("bounce_e%0d_db", e),  SW_DB, (e >= 6) ? 16'h0100 : 16'h0000);
            chk($sformatf("bounce_e%0d_chg", e), {15'b0, CHANGED}, {15'b0, (e == 6)});
        end

        // staggered independent bits: SW[15] at t, SW[3] at t+2
        SW = 16'h8100;
        for (int e = 1; e <= 10; e++) begin
            if (e == 3) SW = 16'h8108;
            cyc();
            chk($sformatf("stag_e%0d_db", e), SW_DB,
                16'h0100 | ((e >= 6) ? 16'h8000 : 16'h0000) | ((e >= 8) ? 16'h0008 : 16'h0000));
            chk($sformatf("stag_e%0d_chg", e), {15'b0, CHANGED}, {15'b0, (e == 6 || e == 8)});
            chk($sformatf("stag_e%0d_stb", e), {15'b0, STABLE},  {15'b0, (e <= 2 || e >= 9)});
        end

        // reset in the middle of a pending count
        SW = 16'h0000;
        for (int i = 0; i < 10; i++) cyc();
        SW = 16'h0F0F;
        for (int e = 1; e <= 3; e++) begin
            cyc();
            chk("rstmid_pre_db", SW_DB, 16'h0000);
        end
        BTNC = 1'b1;
        cyc();
        chk("rstmid_rst_db",  SW_DB, 16'h0000);
        chk("rstmid_rst_stb", {15'b0, STABLE}, 16'h0000);
        BTNC = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            cyc();
            chk($sformatf("rstmid_e%0d_db", e),  SW_DB, (e >= 6) ? 16'h0F0F : 16'h0000);
            chk($sformatf("rstmid_e%0d_chg", e), {15'b0, CHANGED}, {15'b0, (e == 6)});
        end

        // randomized traffic: single-bit flips, bursts, occasional resets
        for (int n = 0; n < 2000; n++) begin
            r    = $urandom_range(0, 99);
            BTNC = (r < 2);
            if (r >= 2 && r < 16) SW = SW ^ (16'h0001 << $urandom_range(0, 15));
            else if (r >= 16 && r < 19) SW = 16'($urandom);
            cyc();
        end
        BTNC = 1'b0;
        for (int i = 0; i < 10; i++) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
